// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO into async serial frames: start, DATA_W bits LSB first, optional even parity, stop.
// Latency: pop edge to tx_o falling is 1 cycle; back-to-back frames are (2+DATA_W+PARITY_EN)*CLK_DIV cycles apart.
// Backpressure: pops only when idle or on the last stop cycle, with enable_i high and the FIFO non-empty.
module fifo_uart_tx #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 16,
  parameter int PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              empty_i,
  input  logic [DATA_W-1:0] pop_data_i,
  output logic              pop_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              par, par_nxt;
  logic              tx_nxt;
  logic              div_last;
  logic              stop_last;

  assign div_last     = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign stop_last    = (state == STOP) && div_last;
  // Gated by reset so no pop strobe reaches the FIFO while the block is held in reset.
  assign pop_o        = reset & enable_i & ~empty_i & ((state == IDLE) | stop_last);
  assign frame_done_o = stop_last;
  assign busy_o       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    par_nxt   = par;
    tx_nxt    = 1'b1;

    if (state != IDLE) begin
      div_nxt = div_last ? '0 : div_cnt + DIV_W'(1);
    end

    case (state)
      START:  if (div_last) state_nxt = DATA;
      DATA: begin
        if (div_last) begin
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            bit_nxt   = '0;
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_nxt   = bit_cnt + BIT_W'(1);
            shreg_nxt = shreg >> 1;
          end
        end
      end
      PARITY: if (div_last) state_nxt = STOP;
      STOP:   if (div_last) state_nxt = IDLE;
      default: ;
    endcase

    // A pop overrides the return to IDLE, giving back-to-back frames.
    if (pop_o) begin
      shreg_nxt = pop_data_i;
      par_nxt   = ^pop_data_i;
      state_nxt = START;
      div_nxt   = '0;
      bit_nxt   = '0;
    end

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      PARITY:  tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tx_o    <= 1'b1;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      par     <= par_nxt;
      tx_o    <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: two transmitters (no parity / even parity, CLK_DIV=4) fed by queue-model FIFOs.
module tb_fifo_uart_tx;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] en_r;
  logic [1:0] empty_r;
  logic [1:0] pop_w;
  logic [1:0] tx_w;
  logic [1:0] busy_w;
  logic [1:0] done_w;
  logic [7:0] data_r [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int         n_chk  = 0;
  int         n_fail = 0;

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [11:0] bits;
    int         nb;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_W(8), .CLK_DIV(4), .PARITY_EN(0)) u0 (
    .clk(clk), .reset(reset), .enable_i(en_r[0]), .empty_i(empty_r[0]),
    .pop_data_i(data_r[0]), .pop_o(pop_w[0]), .tx_o(tx_w[0]),
    .busy_o(busy_w[0]), .frame_done_o(done_w[0])
  );

  fifo_uart_tx #(.DATA_W(8), .CLK_DIV(4), .PARITY_EN(1)) u1 (
    .clk(clk), .reset(reset), .enable_i(en_r[1]), .empty_i(empty_r[1]),
    .pop_data_i(data_r[1]), .pop_o(pop_w[1]), .tx_o(tx_w[1]),
    .busy_o(busy_w[1]), .frame_done_o(done_w[1])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fifo_drive();
    empty_r[0] = (q0.size() == 0);
    empty_r[1] = (q1.size() == 0);
    data_r[0]  = (q0.size() != 0) ? q0[0] : 8'h00;
    data_r[1]  = (q1.size() != 0) ? q1[0] : 8'h00;
  endtask

  // Advance one clock; the FIFO model retires a word when pop was high before the edge.
  task automatic tick();
    logic p0, p1;
    p0 = pop_w[0];
    p1 = pop_w[1];
    @(posedge clk);
    #1;
    if (p0 && q0.size() != 0) q0.delete(0);
    if (p1 && q1.size() != 0) q1.delete(0);
    fifo_drive();
    #1;
  endtask

  task automatic push(input int sel, input logic [7:0] d);
    if (sel == 0) q0.push_back(d);
    else          q1.push_back(d);
    fifo_drive();
    #1;
  endtask

  // Expects the DUT idle with the word at the FIFO head; exp bit k is the level of frame bit k.
  task automatic run_frame(input string nm, input int sel, input logic [11:0] exp, input int nb);
    int         waited  = 0;
    int         f       = nb * 4;
    int         done_at = -1;
    int         ndone   = 0;
    int         npop    = 0;
    logic       busy_ok = 1'b1;
    logic       tx_s [0:48];
    logic [3:0] got;
    while (!pop_w[sel] && waited < 100) begin
      tick();
      waited++;
    end
    check({nm, "_pop"}, 32'(pop_w[sel]), 32'h1);
    if (!pop_w[sel]) return;
    tick();
    for (int c = 1; c <= f; c++) begin
      tx_s[c] = tx_w[sel];
      if (done_w[sel]) begin ndone++; done_at = c; end
      if (pop_w[sel]) npop++;
      if (!busy_w[sel]) busy_ok = 1'b0;
      tick();
    end
    for (int k = 0; k < nb; k++) begin
      got = {tx_s[4*k+4], tx_s[4*k+3], tx_s[4*k+2], tx_s[4*k+1]};
      check($sformatf("%s_bit%0d", nm, k), 32'(got), exp[k] ? 32'hF : 32'h0);
    end
    check({nm, "_done_cycle"}, done_at, f);
    check({nm, "_done_count"}, ndone, 1);
    check({nm, "_extra_pop"}, npop, 0);
    check({nm, "_busy_during"}, 32'(busy_ok), 32'h1);
    check({nm, "_busy_after"}, 32'(busy_w[sel]), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    int nd;
    int last;
    int run;

    // frame levels as {stop, [parity], data LSB-first, start}
    vecs[0] = '{0, 8'hA5, 12'h34A, 10};
    vecs[1] = '{0, 8'h00, 12'h200, 10};
    vecs[2] = '{0, 8'hFF, 12'h3FE, 10};
    vecs[3] = '{1, 8'h07, 12'h60E, 11};
    vecs[4] = '{1, 8'h03, 12'h406, 11};

    en_r = 2'b11;
    q0.push_back(8'hA5);
    fifo_drive();
    #1 reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check($sformatf("reset_hold%0d", i), {29'd0, tx_w[0], pop_w[0], busy_w[0]}, 32'h4);
    end
    reset = 1'b1;
    #1;
    check("first_pop_after_release", 32'(pop_w[0]), 32'h1);

    for (int i = 0; i < 5; i++) begin
      if (i != 0) push(vecs[i].sel, vecs[i].data);
      run_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].bits, vecs[i].nb);
    end

    // Burst of 8 words: back-to-back frames 40 cycles apart.
    for (int d = 0; d < 8; d++) q0.push_back(8'(d));
    fifo_drive();
    #1;
    np = 0; last = 0; run = 0;
    for (int c = 0; c < 380; c++) begin
      run = tx_w[0] ? run + 1 : 0;
      if (pop_w[0]) begin
        if (np > 0) begin
          check("burst_spacing", c - last, 40);
          check("burst_idle_high", run, 4);
          check("burst_done_with_pop", 32'(done_w[0]), 32'h1);
        end
        last = c;
        np++;
      end
      tick();
    end
    check("burst_pop_count", np, 8);
    check("burst_busy_end", 32'(busy_w[0]), 32'h0);
    check("burst_empty_end", 32'(empty_r[0]), 32'h1);

    // Reset during data bit 3 of 0x55 (bit 3 is 0).
    q0.push_back(8'h55);
    q0.push_back(8'h3C);
    fifo_drive();
    #1;
    check("mr_pop", 32'(pop_w[0]), 32'h1);
    tick();
    repeat (17) tick();
    check("mr_bit3_low", 32'(tx_w[0]), 32'h0);
    check("mr_busy_before", 32'(busy_w[0]), 32'h1);
    reset = 1'b0;
    #1;
    check("mr_tx_async", 32'(tx_w[0]), 32'h1);
    check("mr_busy_async", 32'(busy_w[0]), 32'h0);
    check("mr_pop_in_reset", 32'(pop_w[0]), 32'h0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mr_next_head", 32'(data_r[0]), 32'h3C);
    run_frame("mr_frame", 0, 12'h278, 10);

    // enable_i gating.
    en_r[0] = 1'b0;
    q0.push_back(8'h81);
    q0.push_back(8'h42);
    fifo_drive();
    #1;
    np = 0;
    repeat (50) begin
      np += int'(pop_w[0]);
      tick();
    end
    check("en_off_no_pop", np, 0);
    en_r[0] = 1'b1;
    #1;
    check("en_on_pop", 32'(pop_w[0]), 32'h1);
    tick();
    tick();
    en_r[0] = 1'b0;
    #1;
    np = 0; nd = 0;
    repeat (100) begin
      np += int'(pop_w[0]);
      nd += int'(done_w[0]);
      tick();
    end
    check("en_drop_no_second_pop", np, 0);
    check("en_drop_frame_done", nd, 1);
    check("en_drop_busy_end", 32'(busy_w[0]), 32'h0);
    check("en_drop_fifo_left", q0.size(), 1);
    q0.delete();
    fifo_drive();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter stage that drains the byte FIFO directly downstream of it. Whenever the FIFO is non-empty and transmission is enabled, it pops one word and shifts it out as an asynchronous serial frame: start bit, data bits LSB first, optional even parity, and stop bit. A fixed clock divider sets the bit period. It connects to the FIFO pop side (pop/pop-data/empty) with no intermediate logic.

## Interface
- DATA_W, 8, data width; must match the FIFO DATA_W.
- CLK_DIV, 16, clock cycles per serial bit; minimum 2.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.

- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 means reset is asserted.
- enable_i  input  1  permits new frames to start.
- empty_i  input  1  FIFO empty flag.
- pop_data_i  input  DATA_W  FIFO head word; show-ahead, valid whenever empty_i=0.
- pop_o  output  1  one-cycle pop strobe to the FIFO.
- tx_o  output  1  serial line; idles high.
- busy_o  output  1  high while a frame is in flight.
- frame_done_o  output  1  one-cycle pulse on the final stop-bit cycle.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_EN=0.
- Pop condition: pop = enable_i & ~empty_i & (state==IDLE | last STOP cycle).
  - pop_o is combinational from registered state and inputs.
  - pop_o is never high while empty_i=1.
- On the pop edge: pop_data_i is captured into the shift register, the parity bit is computed as XOR of the data bits, and the FSM enters START.
- START: tx_o=0 for CLK_DIV cycles.
- DATA: DATA_W bits, LSB first, CLK_DIV cycles each.
  - The shift register shifts right.
  - The bit counter counts 0..DATA_W-1.
- PARITY: tx_o = XOR of the data bits for CLK_DIV cycles.
- STOP: tx_o=1 for CLK_DIV cycles.
  - On its last cycle: frame_done_o=1.
  - If the pop condition also holds on that cycle, the next frame's pop happens on that cycle and START follows directly (back-to-back, no extra idle).
  - Otherwise the FSM returns to IDLE.
- Counter widths:
  - Divider counter: $clog2(CLK_DIV) bits, counts 0..CLK_DIV-1 and wraps.
  - Bit counter: $clog2(DATA_W) bits, minimum 1.
- busy_o=1 in every state except IDLE.
- tx_o is registered: a state change appears on tx_o on the cycle after the edge that causes it.
- enable_i deasserted mid-frame: the current frame completes unchanged; no further pop occurs.

## Timing
- Reset values: tx_o=1, pop_o=0, busy_o=0, frame_done_o=0, state IDLE, all counters 0.
  - Reset is asynchronous: tx_o goes high immediately, even mid-frame.
  - A word already popped when reset asserts is discarded.
- Latency: pop edge to tx_o falling is 1 cycle.
- Frame length F = (2 + DATA_W + PARITY_EN) × CLK_DIV cycles, measured from the pop edge to the next possible pop edge.
- Back-to-back pops are spaced exactly F cycles apart.
- The first pop after reset release can occur in the first cycle with reset=1, enable_i=1 and empty_i=0.
- frame_done_o and a back-to-back pop_o can be high in the same cycle.

## Test plan
- Reset held low for 3 cycles, FIFO non-empty → tx_o=1, pop_o=0, busy_o=0 throughout; first pop only after release.
- Single byte 0xA5, CLK_DIV=4, PARITY_EN=0:
  - Exactly one pop_o cycle.
  - tx_o bits, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1.
  - frame_done_o on cycle 40; busy_o falls afterwards.
- FIFO filled with 8 words 0x00..0x07, CLK_DIV=4:
  - 8 pops spaced exactly 40 cycles apart.
  - tx_o never high longer than one stop bit between frames.
  - After the last frame: empty_i=1, no further pop, busy_o=0.
- PARITY_EN=1, bytes 0x07 then 0x03, CLK_DIV=4:
  - Parity bits are 1 and 0 respectively.
  - Frames are 44 cycles each.
- Reset asserted during data bit 3:
  - tx_o goes to 1 immediately and busy_o=0.
  - After release, the next FIFO word is popped and sent in full.
- enable_i=0 with FIFO non-empty → no pop for 50 cycles. Then raise enable_i and drop it during the START bit → that frame completes and no second pop occurs.
